// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding and datapath select constants for cache_control
package cache_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} cache_state_t;
  localparam logic DSEL_CPU  = 1'b0;
  localparam logic DSEL_PMEM = 1'b1;
  localparam logic ASEL_CPU  = 1'b0;
  localparam logic ASEL_WB   = 1'b1;
endpackage

// File: rtl/cache_control_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and asynchronous reset
module sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [width-1:0] count
);
  logic [width-1:0] count_q, count_d;
  // clear wins over increment; hold at all-ones
  always_comb count_d = clear ? '0 : (inc && !(&count_q)) ? count_q + width'(1) : count_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/cache_control.sv
// cache_control: FSM controller for a direct-mapped write-back write-allocate cache.
// Define CACHE_PERF_EN to add hit/miss/writeback performance counters.
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int ctr_width = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_data,
  output logic load_tag,
  output logic load_valid,
  output logic load_dirty,
  output logic dirty_in,
  output logic datain_sel,
  output logic addr_sel
`ifdef CACHE_PERF_EN
  ,
  input  logic                 perf_clear,
  output logic [ctr_width-1:0] hit_count,
  output logic [ctr_width-1:0] miss_count,
  output logic [ctr_width-1:0] wb_count
`endif
);
  if (ctr_width < 1) begin : g_bad_width
    $error("ctr_width must be at least 1");
  end
  cache_state_t state_q, state_d;
  logic req, chk_hit, fill;
  assign req = mem_read | mem_write;
  // state register; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state; a dropped request falls through CHECK back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = req ? CHECK : IDLE;
      CHECK:     state_d = (!req || hit) ? IDLE : dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: state_d = pmem_resp ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_d = pmem_resp ? CHECK : ALLOCATE;
      default:   state_d = IDLE;
    endcase
  end
  // output decode; a write with both request bits set is treated as a write
  always_comb begin
    chk_hit    = (state_q == CHECK) && req && hit;
    fill       = (state_q == ALLOCATE) && pmem_resp;
    mem_resp   = chk_hit;
    pmem_read  = state_q == ALLOCATE;
    pmem_write = state_q == WRITEBACK;
    dirty_in   = chk_hit && mem_write;
    load_data  = dirty_in || fill;
    load_dirty = dirty_in || fill;
    load_tag   = fill;
    load_valid = fill;
    datain_sel = fill ? DSEL_PMEM : DSEL_CPU;
    addr_sel   = (state_q == WRITEBACK) ? ASEL_WB : ASEL_CPU;
  end
`ifdef CACHE_PERF_EN
  logic miss_inc, wb_inc;
  assign miss_inc = (state_q == CHECK) && req && !hit;
  assign wb_inc   = (state_q == WRITEBACK) && pmem_resp;
  sat_counter #(.width(ctr_width)) u_hit  (.clk(clk), .rst(rst), .clear(perf_clear), .inc(chk_hit),  .count(hit_count));
  sat_counter #(.width(ctr_width)) u_miss (.clk(clk), .rst(rst), .clear(perf_clear), .inc(miss_inc), .count(miss_count));
  sat_counter #(.width(ctr_width)) u_wb   (.clk(clk), .rst(rst), .clear(perf_clear), .inc(wb_inc),   .count(wb_count));
`endif
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed self-checking bench for cache_control (CACHE_PERF_EN optional)
module tb_cache_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, dirty = 1'b0, pmem_resp = 1'b0;
  logic [9:0] outs;
  logic [9:0] sb[$];
  int n_cmp = 0, n_fail = 0;
  // {mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid, load_dirty, dirty_in, datain_sel, addr_sel}
  localparam logic [9:0] NONE = 10'b0000000000;
  localparam logic [9:0] RHIT = 10'b1000000000;
  localparam logic [9:0] WHIT = 10'b1001001100;
  localparam logic [9:0] WB   = 10'b0010000001;
  localparam logic [9:0] AL   = 10'b0100000000;
  localparam logic [9:0] FILL = 10'b0101111010;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .dirty(dirty),
    .pmem_resp(pmem_resp), .mem_resp(outs[9]), .pmem_read(outs[8]), .pmem_write(outs[7]),
    .load_data(outs[6]), .load_tag(outs[5]), .load_valid(outs[4]), .load_dirty(outs[3]),
    .dirty_in(outs[2]), .datain_sel(outs[1]), .addr_sel(outs[0])
`ifdef CACHE_PERF_EN
    , .perf_clear(perf_clear), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

`ifdef CACHE_PERF_EN
  logic perf_clear = 1'b0;
  logic [31:0] hit_count, miss_count, wb_count;
  logic [9:0] outs2;
  logic [1:0] hit_count2, miss_count2, wb_count2;
  cache_control #(.ctr_width(2)) dut2 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .dirty(dirty),
    .pmem_resp(pmem_resp), .mem_resp(outs2[9]), .pmem_read(outs2[8]), .pmem_write(outs2[7]),
    .load_data(outs2[6]), .load_tag(outs2[5]), .load_valid(outs2[4]), .load_dirty(outs2[3]),
    .dirty_in(outs2[2]), .datain_sel(outs2[1]), .addr_sel(outs2[0]),
    .perf_clear(1'b0), .hit_count(hit_count2), .miss_count(miss_count2), .wb_count(wb_count2)
  );
`endif

  // compare the current outputs against the oldest scoreboard entry
  task automatic check_now(input string tag);
    logic [9:0] e;
    e = sb.pop_front();
    n_cmp++;
    assert (outs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, outs, e);
    end
  endtask

  // one clock cycle: queue expectation, sample at negedge, advance to just after the next posedge
  task automatic step(input string tag, input logic [9:0] e);
    sb.push_back(e);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] e);
    n_cmp++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, e);
    end
  endtask

  task automatic hit_access(input logic rd, input logic wr, input string tag);
    mem_read = rd; mem_write = wr; hit = 1'b1;
    step({tag, "_idle"}, NONE);
    step({tag, "_resp"}, wr ? WHIT : RHIT);
    mem_read = 1'b0; mem_write = 1'b0;
    step({tag, "_after"}, NONE);
  endtask

  task automatic miss_access(input logic wr, input logic dty, input int wb_wait, input int al_wait, input string tag);
    mem_read = !wr; mem_write = wr; hit = 1'b0; dirty = dty;
    step({tag, "_idle"}, NONE);
    step({tag, "_check"}, NONE);
    if (dty) begin
      repeat (wb_wait - 1) step({tag, "_wb"}, WB);
      pmem_resp = 1'b1;
      step({tag, "_wb_resp"}, WB);
      pmem_resp = 1'b0; dirty = 1'b0;
    end
    repeat (al_wait - 1) step({tag, "_alloc"}, AL);
    pmem_resp = 1'b1;
    step({tag, "_fill"}, FILL);
    pmem_resp = 1'b0; hit = 1'b1;
    step({tag, "_recheck"}, wr ? WHIT : RHIT);
    mem_read = 1'b0; mem_write = 1'b0;
    step({tag, "_after"}, NONE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_read = 1'b1; hit = 1'b1;
    step("reset0", NONE);
    step("reset1", NONE);
    rst = 1'b0; mem_read = 1'b0; hit = 1'b0;
    step("idle_quiet", NONE);
    hit_access(1'b1, 1'b0, "read_hit");
    hit_access(1'b0, 1'b1, "write_hit");
    hit_access(1'b1, 1'b1, "rw_as_write");
    // request held across mem_resp: an IDLE cycle must separate the two accesses
    mem_write = 1'b1; hit = 1'b1;
    step("b2b_idle0", NONE);
    step("b2b_resp0", WHIT);
    step("b2b_idle1", NONE);
    step("b2b_resp1", WHIT);
    mem_write = 1'b0;
    step("b2b_after", NONE);
    miss_access(1'b0, 1'b0, 0, 5, "clean_rd_miss");
    miss_access(1'b1, 1'b1, 3, 3, "dirty_wr_miss");
    // request dropped in CHECK
    mem_read = 1'b1; hit = 1'b0; dirty = 1'b0;
    step("drop_chk_idle", NONE);
    mem_read = 1'b0;
    step("drop_chk_check", NONE);
    step("drop_chk_after", NONE);
    // request dropped in ALLOCATE: fill completes, re-check gives no mem_resp
    mem_read = 1'b1;
    step("drop_al_idle", NONE);
    step("drop_al_check", NONE);
    step("drop_al_alloc0", AL);
    mem_read = 1'b0;
    step("drop_al_alloc1", AL);
    pmem_resp = 1'b1;
    step("drop_al_fill", FILL);
    pmem_resp = 1'b0; hit = 1'b1;
    step("drop_al_recheck", NONE);
    step("drop_al_after", NONE);
    // asynchronous reset in the middle of ALLOCATE
    mem_read = 1'b1; hit = 1'b0;
    step("rst_mid_idle", NONE);
    step("rst_mid_check", NONE);
    step("rst_mid_alloc", AL);
    sb.push_back(AL);
    check_now("rst_mid_pre");
    #2 rst = 1'b1;
    #1 sb.push_back(NONE);
    check_now("rst_mid_async");
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    @(posedge clk);
    #1 pmem_resp = 1'b1;
    step("stray_resp", NONE);
    pmem_resp = 1'b0;
    step("stray_after", NONE);
`ifdef CACHE_PERF_EN
    rst = 1'b1;
    #2 cmp("perf_rst_hit", hit_count, 0);
    cmp("perf_rst_miss", miss_count, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    hit_access(1'b1, 1'b0, "p_hit0");
    hit_access(1'b0, 1'b1, "p_hit1");
    hit_access(1'b1, 1'b0, "p_hit2");
    miss_access(1'b0, 1'b0, 0, 2, "p_clean");
    miss_access(1'b1, 1'b1, 2, 2, "p_dirty");
    cmp("perf_hit", hit_count, 5);
    cmp("perf_miss", miss_count, 2);
    cmp("perf_wb", wb_count, 1);
    cmp("sat_hit", {30'b0, hit_count2}, 3);
    cmp("sat_miss", {30'b0, miss_count2}, 2);
    cmp("sat_wb", {30'b0, wb_count2}, 1);
    mem_read = 1'b1; hit = 1'b1;
    step("pclr_idle", NONE);
    perf_clear = 1'b1;
    step("pclr_resp", RHIT);
    perf_clear = 1'b0; mem_read = 1'b0;
    cmp("pclr_hit", hit_count, 0);
    cmp("pclr_miss", miss_count, 0);
    cmp("pclr_wb", wb_count, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- FSM controller for a direct-mapped, write-back, write-allocate cache.
- Sequences the cache datapath's data, tag, valid and dirty arrays: generates their write strobes and mux selects, and runs the line-sized physical-memory handshake.
- Sits between the CPU-side request port and physical memory. Its only inputs from the datapath are combinational hit/dirty status read asynchronously from the arrays at the current index.

Parameters:
- ctr_width, 32, width of the performance counters (used only with CACHE_PERF_EN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  CPU read request; held stable until mem_resp
- mem_write  in  1  CPU write request; held stable until mem_resp
- hit  in  1  datapath: valid && tag match at the current index
- dirty  in  1  datapath: dirty bit at the current index
- pmem_resp  in  1  physical memory: one-cycle completion pulse
- mem_resp  out  1  CPU request complete (one-cycle pulse)
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- load_data  out  1  data array write strobe
- load_tag  out  1  tag array write strobe
- load_valid  out  1  valid array write strobe
- load_dirty  out  1  dirty array write strobe
- dirty_in  out  1  value written to the dirty array
- datain_sel  out  1  data array input select: 0 = CPU merge, 1 = pmem line
- addr_sel  out  1  pmem address select: 0 = CPU address, 1 = writeback address (stored tag + index)

Behaviour:
- States: IDLE, CHECK, WRITEBACK, ALLOCATE. Registered state; outputs decoded combinationally from state and inputs.
- Reset: state = IDLE. Every output is 0 while rst is high and in IDLE. An assertion mid-miss abandons the pmem transaction immediately; the array contents are left as-is.
- IDLE:
  - All outputs 0.
  - mem_read or mem_write -> CHECK on the next edge.
- CHECK, hit = 1:
  - mem_resp = 1 this cycle -> IDLE.
  - If mem_write: also load_data = 1, datain_sel = 0, load_dirty = 1, dirty_in = 1.
- CHECK, hit = 0:
  - dirty = 1 -> WRITEBACK; dirty = 0 -> ALLOCATE.
  - No strobes asserted.
- CHECK, no request (request dropped): -> IDLE with no mem_resp.
- WRITEBACK:
  - pmem_write = 1 and addr_sel = 1 in every cycle of the state.
  - On pmem_resp -> ALLOCATE; array not written.
- ALLOCATE:
  - pmem_read = 1 and addr_sel = 0 in every cycle of the state.
  - On pmem_resp, same cycle: load_data = 1, datain_sel = 1, load_tag = 1, load_valid = 1, load_dirty = 1, dirty_in = 0 -> CHECK.
  - The re-check then hits and completes the access, merging a write.
- Latency:
  - Hit: request seen in IDLE at edge t, mem_resp during cycle t+1 (2 cycles).
  - Clean miss: 3 cycles + memory wait.
  - Dirty miss: 4 cycles + both memory waits.
- pmem_read and pmem_write are mutually exclusive and held until pmem_resp. A pmem_resp arriving in IDLE or CHECK is ignored.
- mem_read and mem_write both high: treated as a write.
- A request dropped during WRITEBACK or ALLOCATE: the memory transaction still completes, then the block returns to IDLE through CHECK with no mem_resp.
- Back-to-back requests: after a mem_resp, at least one IDLE cycle occurs before the next CHECK.

Optional Feature:
- Macro: CACHE_PERF_EN.
- Defined:
  - Adds input perf_clear (1) and outputs hit_count, miss_count, wb_count (ctr_width each).
  - hit_count increments on each CHECK cycle with hit = 1 that asserts mem_resp; re-checks after a fill count as hits.
  - miss_count increments on each CHECK -> WRITEBACK or CHECK -> ALLOCATE transition.
  - wb_count increments on each WRITEBACK pmem_resp.
  - Counters saturate at all-ones. perf_clear zeros them synchronously and has priority over an increment in the same cycle. rst zeros them asynchronously.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package cache_ctrl_pkg:
  - enum cache_state_t {IDLE, CHECK, WRITEBACK, ALLOCATE}.
  - datain_sel constants DSEL_CPU = 0, DSEL_PMEM = 1.
  - addr_sel constants ASEL_CPU = 0, ASEL_WB = 1.
- Sub-module sat_counter (parameter width; ports clk, rst, clear, inc, count), instantiated 3x only under CACHE_PERF_EN.

Test Plan:
- Read hit: hit = 1, mem_read pulse held -> mem_resp in cycle 2, all load_* = 0, no pmem activity.
- Write hit: hit = 1, mem_write -> cycle 2 asserts mem_resp, load_data, load_dirty, dirty_in = 1, datain_sel = 0.
- Clean read miss with pmem_resp after 5 cycles:
  - ALLOCATE asserts pmem_read for 5 cycles with addr_sel = 0.
  - In the fill cycle load_tag, load_valid and load_data are 1 with datain_sel = 1 and dirty_in = 0.
  - The bench then drives hit = 1 -> mem_resp 1 cycle later.
- Dirty write miss, pmem_resp latency 3 each way:
  - WRITEBACK asserts pmem_write with addr_sel = 1 for 3 cycles, then ALLOCATE asserts pmem_read for 3 cycles.
  - The CHECK write merge asserts dirty_in = 1; total latency is 10 cycles.
- rst asserted mid-ALLOCATE (asynchronous, between edges) -> pmem_read drops immediately and the block is in IDLE. A stray pmem_resp one cycle later -> no strobes.
- CACHE_PERF_EN defined:
  - 3 hits, 1 clean miss, 1 dirty miss -> hit_count = 5, miss_count = 2, wb_count = 1.
  - perf_clear together with a hit -> all counters 0.
  - With ctr_width = 2, 5 hits -> hit_count = 3.
